srff_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares a bank of NFLAGS clocked SR flip-flops between NREQ requesters.
- Each request is one set or reset of one flag. The block drives a single-cycle s or r pulse into the bank, optionally reads q back, and reports done/err.
- Guarantees the bank never sees s=r=1 and never sees more than one active input per cycle.

---
 rtl/srff_bank_arbiter_if.sv | 27 ++
 rtl/srff_bank_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_srff_bank_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/srff_bank_arbiter_if.sv
// Requester handshake and SR-bank drive/readback bundle for srff_bank_arbiter.
// master = requesters plus bank side, slave = the arbiter.
interface srff_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_set;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic                 err;
    logic [NFLAGS-1:0]    s_out;
    logic [NFLAGS-1:0]    r_out;
    logic [NFLAGS-1:0]    q_in;

    modport master (
        output req, req_set, req_idx, q_in,
        input  gnt, done, err, s_out, r_out
    );

    modport slave (
        input  req, req_set, req_idx, q_in,
        output gnt, done, err, s_out, r_out
    );
endinterface

// File: rtl/srff_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing a bank of SR flip-flops between requesters.
// Define SRFF_ARB_READBACK_EN to enable q readback checking with timeout.

// One lane per flag: registers the single-cycle s or r pulse for its own flag.
module srff_bank_arbiter_lane #(
    parameter int IDXW = 3,
    parameter int LANE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_fire,
    input  logic            i_set,
    input  logic [IDXW-1:0] i_idx,
    output logic            o_s,
    output logic            o_r
);
    localparam logic [IDXW-1:0] LIDX = IDXW'(LANE);

    logic w_sel;
    logic r_s;
    logic r_r;

    assign w_sel = i_fire && (i_idx == LIDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= 1'b0;
            r_r <= 1'b0;
        end else begin
            r_s <= w_sel & i_set;
            r_r <= w_sel & ~i_set;
        end
    end

    assign o_s = r_s;
    assign o_r = r_r;
endmodule

module srff_bank_arbiter #(
    parameter int NREQ    = 4,
    parameter int NFLAGS  = 8,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 4
) (
    input logic              clk,
    input logic              rst_n,
    srff_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

`ifdef SRFF_ARB_READBACK_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic              r_done;
    logic              r_err;

    logic              w_found;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_nxt_ptr;
    logic              w_set;
    logic [IDXW-1:0]   w_idx;
    logic              w_inrng;
    logic              w_fire;
    logic [NFLAGS-1:0] w_s;
    logic [NFLAGS-1:0] w_r;

`ifdef SRFF_ARB_READBACK_EN
    logic [CW-1:0]        r_cnt;
    logic                 r_set;
    logic [IDXW-1:0]      r_idx;
    logic [2**IDXW-1:0]   w_q_pad;
    logic                 w_hit;

    // Pad q so an IDXW-wide index is always a legal select.
    always_comb begin
        w_q_pad             = '0;
        w_q_pad[NFLAGS-1:0] = bus.q_in;
    end
    assign w_hit = w_q_pad[r_idx];
`endif

    // Scan downward so the last hit, i.e. the nearest at/after the pointer, wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_set     = bus.req_set[w_win];
    assign w_idx     = bus.req_idx[int'(w_win)*IDXW +: IDXW];
    assign w_inrng   = int'(w_idx) < NFLAGS;
    assign w_nxt_ptr = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_fire    = (r_state == IDLE) && w_found && w_inrng;

    for (genvar f = 0; f < NFLAGS; f++) begin : g_lane
        srff_bank_arbiter_lane #(
            .IDXW (IDXW),
            .LANE (f)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_fire (w_fire),
            .i_set  (w_set),
            .i_idx  (w_idx),
            .o_s    (w_s[f]),
            .o_r    (w_r[f])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef SRFF_ARB_READBACK_EN
            r_cnt   <= '0;
            r_set   <= 1'b0;
            r_idx   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt <= GNT_ONE << w_win;
                        r_ptr <= w_nxt_ptr;
`ifdef SRFF_ARB_READBACK_EN
                        r_set <= w_set;
                        r_idx <= w_idx;
`endif
                        if (w_inrng) begin
                            r_state <= DRIVE;
                        end else begin
                            // Nothing is driven for a bad index; finish immediately.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
`ifdef SRFF_ARB_READBACK_EN
                    r_state <= CHECK;
                    r_cnt   <= '0;
`else
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_err   <= 1'b0;
`endif
                end
`ifdef SRFF_ARB_READBACK_EN
                CHECK: begin
                    if (w_hit == r_set) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.s_out = w_s;
    assign bus.r_out = w_r;
endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Self-checking bench for srff_bank_arbiter: vector table, done scoreboard,
// hand sequences for contention, readback timeout and reset mid-operation.
module tb_srff_bank_arbiter;
    localparam int NREQ    = 4;
    localparam int NFLAGS  = 6;
    localparam int IDXW    = 3;
    localparam int TIMEOUT = 4;
`ifdef SRFF_ARB_READBACK_EN
    localparam bit RB  = 1'b1;
    localparam int LAT = 2;
`else
    localparam bit RB  = 1'b0;
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [NREQ-1:0]      req;
        logic [NREQ-1:0]      set;
        logic [NREQ*IDXW-1:0] idx;
        logic [NREQ-1:0]      gnt;
        logic [NFLAGS-1:0]    s;
        logic [NFLAGS-1:0]    r;
        logic                 err;
        int                   lat;
        int                   pc;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bank_clr = 1'b1;
    logic [NFLAGS-1:0] bank;
    logic [NFLAGS-1:0] hold0 = '0;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[8];

    srff_bank_arbiter_if #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) bus ();

    srff_bank_arbiter #(
        .NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // SR bank stub; hold0 pins selected q bits low to force readback mismatches.
    always @(posedge clk) begin
        if (bank_clr) bank <= '0;
        else          bank <= (bank | bus.s_out) & ~bus.r_out;
    end
    assign bus.q_in = bank & ~hold0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ*IDXW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {IDXW'(a3), IDXW'(a2), IDXW'(a1), IDXW'(a0)};
    endfunction

    // Invariants plus scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_s_and_r", 32'(bus.s_out & bus.r_out), 0);
            chk("inv_pulse_le1", 32'($countones(bus.s_out | bus.r_out) <= 1), 1);
            chk("inv_gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
            if (bus.done) begin
                chk("inv_done_gnt", 32'(bus.gnt != '0), 1);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_done_gnt", 32'(bus.gnt), 32'(mon_e.gnt));
                    chk("sb_done_err", 32'(bus.err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        bus.req = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sbq.delete();
        rst_n = 1'b1;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        int pc;
        @(negedge clk);
        bus.req     = v.req;
        bus.req_set = v.set;
        bus.req_idx = v.idx;
        sbq.push_back('{gnt: v.gnt, err: v.err});
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(v.gnt));
        chk({tag, "_s"}, 32'(bus.s_out), 32'(v.s));
        chk({tag, "_r"}, 32'(bus.r_out), 32'(v.r));
        bus.req = '0;
        lat = 0;
        pc  = (|(bus.s_out | bus.r_out)) ? 1 : 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (|(bus.s_out | bus.r_out)) pc++;
        end
        chk({tag, "_done_lat"}, 32'(lat), 32'(v.lat));
        chk({tag, "_pulses"}, 32'(pc), 32'(v.pc));
        @(negedge clk);
        chk({tag, "_release"}, 32'({bus.done, bus.err, bus.gnt}), 0);
    endtask

    initial begin
        logic [NREQ-1:0] got[6];
        logic [NREQ-1:0] exp_ord[6];
        logic [NREQ-1:0] prev;
        int ng;
        int cyc;
        vec_t v;

        bus.req = '0;
        bus.req_set = '0;
        bus.req_idx = '0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_s", 32'(bus.s_out), 0);
        chk("rst_r", 32'(bus.r_out), 0);
        repeat (2) @(negedge clk);
        bank_clr = 1'b0;
        rst_n = 1'b1;

        // Pointer advances past each winner; comments give the pointer before each row.
        tbl[0] = '{4'b0001, 4'b0001, pk(3,0,0,0), 4'b0001, 6'h08, 6'h00, 1'b0, LAT, 1}; // ptr0
        tbl[1] = '{4'b0010, 4'b0000, pk(0,3,0,0), 4'b0010, 6'h00, 6'h08, 1'b0, LAT, 1}; // ptr1
        tbl[2] = '{4'b0100, 4'b0100, pk(0,0,0,0), 4'b0100, 6'h01, 6'h00, 1'b0, LAT, 1}; // ptr2
        tbl[3] = '{4'b1000, 4'b1000, pk(0,0,0,5), 4'b1000, 6'h20, 6'h00, 1'b0, LAT, 1}; // ptr3
        tbl[4] = '{4'b0001, 4'b0001, pk(7,0,0,0), 4'b0001, 6'h00, 6'h00, 1'b1, 0,   0}; // ptr0
        tbl[5] = '{4'b0011, 4'b0011, pk(2,4,0,0), 4'b0010, 6'h10, 6'h00, 1'b0, LAT, 1}; // ptr1
        tbl[6] = '{4'b1001, 4'b0000, pk(1,0,0,6), 4'b1000, 6'h00, 6'h00, 1'b1, 0,   0}; // ptr2
        tbl[7] = '{4'b0001, 4'b0000, pk(0,0,0,0), 4'b0001, 6'h00, 6'h01, 1'b0, LAT, 1}; // ptr0
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) chk("bank_q3_set", 32'(bank[3]), 1);
        end

        // Readback timeout: q[5] pinned low while setting flag 5.
        hold0 = 6'h20;
        v = '{4'b0001, 4'b0001, pk(5,0,0,0), 4'b0001, 6'h20, 6'h00, RB, RB ? TIMEOUT + 1 : 1, 1};
        do_op(v, "timeout");
        hold0 = '0;

        // Reset during DRIVE aborts everything; the pointer returns to 0.
        @(negedge clk);
        bus.req = 4'b0001;
        bus.req_set = 4'b0001;
        bus.req_idx = pk(4,0,0,0);
        @(negedge clk);
        chk("abort_s_pre", 32'(bus.s_out), 32'h10);
        bus.req = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outs", 32'({bus.gnt, bus.done, bus.err, bus.s_out, bus.r_out}), 0);
        repeat (2) @(negedge clk);
        sbq.delete();
        rst_n = 1'b1;
        v = '{4'b0011, 4'b0011, pk(4,1,0,0), 4'b0001, 6'h10, 6'h00, 1'b0, LAT, 1};
        do_op(v, "post_rst");

        // Contention: 0 and 2 together, then all four held -> 0,2,3,0,1,2.
        do_reset();
        exp_ord = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int i = 0; i < 6; i++) sbq.push_back('{gnt: exp_ord[i], err: 1'b0});
        bus.req_set = 4'b1111;
        bus.req_idx = pk(0,1,2,3);
        bus.req = 4'b0101;
        prev = '0;
        ng = 0;
        cyc = 0;
        while ((ng < 6 || sbq.size() != 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt != '0 && prev == '0) begin
                got[ng] = bus.gnt;
                ng++;
                if (ng == 2) bus.req = 4'b1111;
                if (ng == 6) bus.req = '0;
            end
            prev = bus.gnt;
        end
        chk("rr_grants_seen", 32'(ng), 6);
        for (int i = 0; i < 6; i++)
            if (i < ng) chk($sformatf("rr_order%0d", i), 32'(got[i]), 32'(exp_ord[i]));
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
